pip_cla_param: RTL and testbench

//  Parametrised, fully pipelined carry-lookahead adder/subtractor with valid tracking, clock enable and async reset.

---
 rtl/pip_cla_pkg.sv | 13 +
 rtl/pip_cla_if.sv | 25 ++
 rtl/cla_blk.sv | 42 ++++
 rtl/pip_cla_param.sv | 124 ++++++++++++
 tb/tb_pip_cla_param.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pip_cla_pkg.sv
// Shared sizing helpers for the pipelined carry-lookahead adder and its bench.
package pip_cla_pkg;

   function automatic int cla_nblk(input int width, input int blk);
      return width / blk;
   endfunction

   // One stage each for operand capture, P/G formation and result, plus one per carry group.
   function automatic int cla_lat(input int width, input int blk);
      return cla_nblk(width, blk) + 3;
   endfunction

endpackage

// File: rtl/pip_cla_if.sv
// Operand/result bus of the pipelined CLA; master drives operands, slave returns results.
interface pip_cla_if #(
   parameter int WIDTH = 20
);
   logic             ce;
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;

   modport master (
      output ce, in_valid, a, b, cin, sub,
      input  out_valid, s, cout, ovf
   );

   modport slave (
      input  ce, in_valid, a, b, cin, sub,
      output out_valid, s, cout, ovf
   );
endinterface

// File: rtl/cla_blk.sv
// Combinational carry-lookahead group: every carry is a flat sum of products of p, g and ci.
module cla_blk #(
   parameter int BLK = 4
) (
   input  logic [BLK-1:0] p,
   input  logic [BLK-1:0] g,
   input  logic           ci,
   output logic [BLK-1:1] c,
   output logic           co,
   output logic           pg,
   output logic           gg
);
   logic [BLK:0] car;
   logic         acc;

   // Mask of bit positions lo..hi-1; used to AND together the propagates of a span.
   function automatic logic [BLK-1:0] span(input int lo, input int hi);
      logic [BLK:0] m;
      m = ((BLK+1)'(1) << hi) - ((BLK+1)'(1) << lo);
      return BLK'(m);
   endfunction

   // NOTE: every variable gets a value on every pass through the block, so no latch is inferred.
   always_comb begin
      car = '0;
      acc = 1'b0;
      for (int i = 0; i <= BLK; i++) begin
         acc = ci & (&(p | ~span(0, i)));
         for (int j = 0; j < i; j++)
            acc = acc | (g[j] & (&(p | ~span(j + 1, i))));
         car[i] = acc;
      end
      gg = 1'b0;
      for (int j = 0; j < BLK; j++)
         gg = gg | (g[j] & (&(p | ~span(j + 1, BLK))));
   end

   assign c  = car[BLK-1:1];
   assign co = car[BLK];
   assign pg = &p;

endmodule

// File: rtl/pip_cla_param.sv
// Fully pipelined carry-lookahead adder/subtractor: one carry group resolved per stage, valid/ce tracked.
module pip_cla_param
   import pip_cla_pkg::*;
#(
   parameter int WIDTH = 20,
   parameter int BLK   = 4
) (
   input logic      clk,
   input logic      rst,
   pip_cla_if.slave bus
);
   localparam int NBLK = cla_nblk(WIDTH, BLK);

   if (WIDTH % BLK != 0 || BLK < 2) begin : g_param_check
      $error("pip_cla_param: WIDTH=%0d must be a multiple of BLK=%0d (BLK >= 2)", WIDTH, BLK);
   end

   logic [WIDTH-1:0] a0_q, b0_q;
   logic             c0_q, v0_q;

   // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a0_q <= '0;
         b0_q <= '0;
         c0_q <= 1'b0;
         v0_q <= 1'b0;
      end else if (bus.ce) begin
         a0_q <= bus.a;
         b0_q <= bus.b ^ {WIDTH{bus.sub}};
         c0_q <= bus.cin ^ bus.sub;
         v0_q <= bus.in_valid;
      end
   end

   // Generates of the still-unresolved groups only; each stage drops the group it just consumed.
   for (genvar j = 0; j < NBLK; j++) begin : g_gp
      logic [WIDTH-j*BLK-1:0] q;
      if (j == 0) begin : g_first
         always_ff @(posedge clk or posedge rst)
            if (rst)          q <= '0;
            else if (bus.ce)  q <= a0_q & b0_q;
      end else begin : g_next
         always_ff @(posedge clk or posedge rst)
            if (rst)          q <= '0;
            else if (bus.ce)  q <= g_gp[j-1].q[WIDTH-(j-1)*BLK-1:BLK];
      end
   end

   // c_q of stage j: bit carries of groups 0..j-1, with the carry into group j on top.
   for (genvar j = 0; j <= NBLK; j++) begin : g_st
      logic [WIDTH-1:0] p_q;
      logic [j*BLK:0]   c_q;
      logic             v_q;

      if (j == 0) begin : g_first
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               p_q <= '0;
               c_q <= '0;
               v_q <= 1'b0;
            end else if (bus.ce) begin
               p_q <= a0_q ^ b0_q;
               c_q <= c0_q;
               v_q <= v0_q;
            end
         end
      end else begin : g_grp
         logic [BLK-1:1] blk_c;
         logic           blk_co, blk_pg, blk_gg;

         cla_blk #(.BLK(BLK)) u_blk (
            .p  (g_st[j-1].p_q[(j-1)*BLK +: BLK]),
            .g  (g_gp[j-1].q[BLK-1:0]),
            .ci (g_st[j-1].c_q[(j-1)*BLK]),
            .c  (blk_c),
            .co (blk_co),
            .pg (blk_pg),
            .gg (blk_gg)
         );

         // Group propagate/generate form must agree with the block's direct carry-out.
         always_comb assert (blk_co == (blk_gg | (blk_pg & g_st[j-1].c_q[(j-1)*BLK])));

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               p_q <= '0;
               c_q <= '0;
               v_q <= 1'b0;
            end else if (bus.ce) begin
               p_q <= g_st[j-1].p_q;
               c_q <= {blk_co, blk_c, g_st[j-1].c_q};
               v_q <= g_st[j-1].v_q;
            end
         end
      end
   end

   logic [WIDTH-1:0] s_q;
   logic             out_valid_q, cout_q, ovf_q;

   // Result registers keep the last result through bubbles and stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         s_q         <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else if (bus.ce) begin
         out_valid_q <= g_st[NBLK].v_q;
         if (g_st[NBLK].v_q) begin
            s_q    <= g_st[NBLK].p_q ^ g_st[NBLK].c_q[WIDTH-1:0];
            cout_q <= g_st[NBLK].c_q[WIDTH];
            ovf_q  <= g_st[NBLK].c_q[WIDTH] ^ g_st[NBLK].c_q[WIDTH-1];
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.s         = s_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pip_cla_param.sv
// Scoreboard bench for pip_cla_param: driver pushes expected results, negedge monitor pops and compares.
module tb_pip_cla_param;
   import pip_cla_pkg::*;

   localparam int WIDTH = 20;
   localparam int BLK   = 4;
   localparam int LAT   = cla_lat(WIDTH, BLK);

   typedef struct {
      logic [WIDTH-1:0] s;
      logic             cout;
      logic             ovf;
      int               due;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   pip_cla_if #(.WIDTH(WIDTH)) bus_if ();

   pip_cla_param #(.WIDTH(WIDTH), .BLK(BLK)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   exp_t             sb[$];
   int               checks   = 0;
   int               failures = 0;
   int               ce_cnt;
   logic             last_ce;
   logic             hold_v, hold_cout, hold_ovf;
   logic [WIDTH-1:0] hold_s;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Counts accepted (ce=1) edges since reset; a result is due a fixed number of them after issue.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ce_cnt  <= 0;
         last_ce <= 1'b0;
      end else begin
         last_ce <= bus_if.ce;
         if (bus_if.ce) ce_cnt <= ce_cnt + 1;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         hold_v    <= 1'b0;
         hold_s    <= '0;
         hold_cout <= 1'b0;
         hold_ovf  <= 1'b0;
         check("reset_outputs", {bus_if.out_valid, bus_if.cout, bus_if.ovf, bus_if.s}, '0);
      end else if (last_ce) begin
         if (sb.size() != 0 && sb[0].due == ce_cnt) begin
            check("out_valid_due", bus_if.out_valid, 1);
            if (bus_if.out_valid) begin
               check("s", bus_if.s, sb[0].s);
               check("cout", bus_if.cout, sb[0].cout);
               check("ovf", bus_if.ovf, sb[0].ovf);
            end
            hold_v    <= 1'b1;
            hold_s    <= sb[0].s;
            hold_cout <= sb[0].cout;
            hold_ovf  <= sb[0].ovf;
            void'(sb.pop_front());
         end else begin
            check("bubble_out_valid", bus_if.out_valid, 0);
            hold_v <= 1'b0;
         end
      end else begin
         check("stall_hold", {bus_if.out_valid, bus_if.cout, bus_if.ovf, bus_if.s},
               {hold_v, hold_cout, hold_ovf, hold_s});
      end
   end

   function automatic exp_t mk(input logic [WIDTH-1:0] s, input logic cout, input logic ovf);
      exp_t e;
      e.s    = s;
      e.cout = cout;
      e.ovf  = ovf;
      e.due  = 0;
      return e;
   endfunction

   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic cin, input logic sub);
      logic [WIDTH-1:0] bb;
      logic [WIDTH:0]   sum;
      bb  = sub ? ~b : b;
      sum = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(cin ^ sub);
      return mk(sum[WIDTH-1:0], sum[WIDTH],
                (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]));
   endfunction

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub, input exp_t e);
      exp_t q;
      q              = e;
      q.due          = ce_cnt + LAT;
      bus_if.ce       = 1'b1;
      bus_if.in_valid = 1'b1;
      bus_if.a        = a;
      bus_if.b        = b;
      bus_if.cin      = cin;
      bus_if.sub      = sub;
      sb.push_back(q);
      step();
   endtask

   task automatic issue_rand();
      logic [WIDTH-1:0] a, b;
      logic             cin, sub;
      a   = WIDTH'($urandom);
      b   = WIDTH'($urandom);
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      issue(a, b, cin, sub, model(a, b, cin, sub));
   endtask

   task automatic idle(input int n);
      bus_if.ce       = 1'b1;
      bus_if.in_valid = 1'b0;
      bus_if.a        = WIDTH'($urandom);
      bus_if.b        = WIDTH'($urandom);
      step(n);
   endtask

   // Operands presented with ce=0 must be ignored entirely.
   task automatic stall(input int n);
      bus_if.ce       = 1'b0;
      bus_if.in_valid = 1'b1;
      bus_if.a        = WIDTH'($urandom);
      bus_if.b        = WIDTH'($urandom);
      step(n);
   endtask

   initial begin
      rst             = 1'b1;
      bus_if.ce       = 1'b0;
      bus_if.in_valid = 1'b0;
      bus_if.a        = '0;
      bus_if.b        = '0;
      bus_if.cin      = 1'b0;
      bus_if.sub      = 1'b0;

      // Reset held with random traffic and a toggling clock enable.
      for (int i = 0; i < 6; i++) begin
         bus_if.ce       = 1'($urandom_range(0, 1));
         bus_if.in_valid = 1'($urandom_range(0, 1));
         bus_if.a        = WIDTH'($urandom);
         bus_if.b        = WIDTH'($urandom);
         step();
      end
      rst = 1'b0;
      idle(LAT + 2);

      // Directed vectors, back to back.
      issue(20'h06F77, 20'h07178, 1'b0, 1'b0, mk(20'h0E0EF, 1'b0, 1'b0));
      issue(20'hFFFFF, 20'h00000, 1'b1, 1'b0, mk(20'h00000, 1'b1, 1'b0));
      issue(20'h00005, 20'h00007, 1'b0, 1'b1, mk(20'hFFFFE, 1'b0, 1'b0));
      issue(20'h7FFFF, 20'h00001, 1'b0, 1'b0, mk(20'h80000, 1'b0, 1'b1));
      issue(20'h00009, 20'h00003, 1'b1, 1'b1, mk(20'h00005, 1'b1, 1'b0));
      idle(LAT + 2);

      // Random stream with bubbles and a 3-cycle stall in the middle.
      for (int i = 0; i < 16; i++) begin
         if (i == 10) stall(3);
         if ($urandom_range(0, 3) == 0) idle(1);
         issue_rand();
      end
      idle(LAT + 2);

      // Reset with five operations in flight: none of them may ever emerge.
      for (int i = 0; i < 5; i++) issue_rand();
      bus_if.in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle(LAT + 4);
      issue(20'h12345, 20'h0ABCD, 1'b0, 1'b0, mk(20'h1CF12, 1'b0, 1'b0));
      idle(LAT + 2);

      check("scoreboard_drained", 64'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
